// File: rtl/ysyx_25040111_pkg.sv
// Shared ysyx_25040111 core definitions: architectural sizes and the
// writeback result bundle.
package ysyx_25040111_pkg;
  localparam int NR_REG = 16;
  localparam int AW     = 4;
  localparam int DW     = 32;
  localparam int CW     = 2;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_res_t;
endpackage

// File: rtl/ysyx_25040111_wbu_if.sv
// Writeback unit bus: issue reservation, ALU/LSU result handshakes,
// register file write port and the per-register busy vector.
interface ysyx_25040111_wbu_if;
  import ysyx_25040111_pkg::*;

  logic              issue_valid;
  logic [AW-1:0]     issue_rd;
  logic              issue_ready;
  logic              alu_valid;
  logic              alu_ready;
  logic [AW-1:0]     alu_rd;
  logic [DW-1:0]     alu_data;
  logic              lsu_valid;
  logic              lsu_ready;
  logic [AW-1:0]     lsu_rd;
  logic [DW-1:0]     lsu_data;
  logic              rf_wen;
  logic [AW-1:0]     rf_waddr;
  logic [DW-1:0]     rf_wdata;
  logic [NR_REG-1:0] busy;

  modport master (
    output issue_valid, issue_rd, alu_valid, alu_rd, alu_data,
           lsu_valid, lsu_rd, lsu_data,
    input  issue_ready, alu_ready, lsu_ready, rf_wen, rf_waddr, rf_wdata, busy
  );

  modport slave (
    input  issue_valid, issue_rd, alu_valid, alu_rd, alu_data,
           lsu_valid, lsu_rd, lsu_data,
    output issue_ready, alu_ready, lsu_ready, rf_wen, rf_waddr, rf_wdata, busy
  );
endinterface

// File: rtl/ysyx_25040111_wbu_sb.sv
// Pending-write scoreboard: one saturating counter per register, bumped on
// issue and released on commit. Register 0 is never tracked.
module ysyx_25040111_wbu_sb
  import ysyx_25040111_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              inc_valid,
  input  logic [AW-1:0]     inc_addr,
  input  logic              dec_valid,
  input  logic [AW-1:0]     dec_addr,
  output logic [NR_REG-1:0] busy,
  output logic              inc_sat
);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [CW-1:0] cnt_q [NR_REG];
  logic [CW-1:0] cnt_d [NR_REG];

  always_comb begin
    for (int i = 0; i < NR_REG; i++) begin
      logic inc_i;
      logic dec_i;
      inc_i    = inc_valid && (inc_addr == AW'(i)) && (i != 0);
      dec_i    = dec_valid && (dec_addr == AW'(i)) && (i != 0);
      cnt_d[i] = cnt_q[i];
      if (inc_i && !dec_i && cnt_q[i] != CNT_MAX)
        cnt_d[i] = cnt_q[i] + CW'(1);
      // A commit with nothing pending is a producer error; clamp at zero.
      else if (dec_i && !inc_i && cnt_q[i] != '0)
        cnt_d[i] = cnt_q[i] - CW'(1);
    end
  end

  // The last outstanding write reads as not busy during its commit cycle,
  // since the register file forwards the write data.
  always_comb begin
    busy = '0;
    for (int i = 1; i < NR_REG; i++)
      busy[i] = (cnt_q[i] != '0) &&
                !(dec_valid && dec_addr == AW'(i) && cnt_q[i] == CW'(1));
  end

  assign inc_sat = (inc_addr != '0) && (cnt_q[inc_addr] == CNT_MAX) &&
                   !(dec_valid && dec_addr == inc_addr);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NR_REG; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NR_REG; i++) cnt_q[i] <= cnt_d[i];
    end
  end
endmodule

// File: rtl/ysyx_25040111_wbu.sv
// Writeback unit: fixed-priority LSU-over-ALU arbitration into a single
// registered register-file write port, plus the RAW pending scoreboard.
module ysyx_25040111_wbu
  import ysyx_25040111_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  ysyx_25040111_wbu_if.slave   bus
);
  wb_res_t res_q, res_d;
  logic    rf_wen_q, rf_wen_d;
  logic    issue_sat;

  assign bus.lsu_ready   = 1'b1;
  assign bus.alu_ready   = !bus.lsu_valid;
  assign bus.issue_ready = !issue_sat;

  always_comb begin
    res_d    = res_q;
    rf_wen_d = 1'b0;
    if (bus.lsu_valid) begin
      res_d    = '{rd: bus.lsu_rd, data: bus.lsu_data};
      rf_wen_d = (bus.lsu_rd != '0);
    end else if (bus.alu_valid) begin
      res_d    = '{rd: bus.alu_rd, data: bus.alu_data};
      rf_wen_d = (bus.alu_rd != '0);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      res_q    <= '0;
      rf_wen_q <= 1'b0;
    end else begin
      res_q    <= res_d;
      rf_wen_q <= rf_wen_d;
    end
  end

  assign bus.rf_wen   = rf_wen_q;
  assign bus.rf_waddr = res_q.rd;
  assign bus.rf_wdata = res_q.data;

  ysyx_25040111_wbu_sb u_sb (
    .clock     (clock),
    .reset     (reset),
    .inc_valid (bus.issue_valid && !issue_sat),
    .inc_addr  (bus.issue_rd),
    .dec_valid (rf_wen_q),
    .dec_addr  (res_q.rd),
    .busy      (bus.busy),
    .inc_sat   (issue_sat)
  );
endmodule

// File: tb/tb_ysyx_25040111_wbu.sv
// Directed bench for the writeback unit: expected writes go into a queue,
// a negedge monitor pops them whenever the write port is enabled.
module tb_ysyx_25040111_wbu;
  import ysyx_25040111_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  wb_res_t exp_q[$];

  ysyx_25040111_wbu_if u_if ();

  ysyx_25040111_wbu dut (
    .clock (clock),
    .reset (reset),
    .bus   (u_if.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] rd, input logic [DW-1:0] data);
    wb_res_t r;
    r.rd   = rd;
    r.data = data;
    exp_q.push_back(r);
  endtask

  // Write-port monitor
  initial begin
    forever begin
      @(negedge clock);
      if (reset && u_if.rf_wen === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {28'b0, u_if.rf_waddr}, 32'hFFFF_FFFF);
        end else begin
          wb_res_t e;
          e = exp_q.pop_front();
          chk("rf_waddr", {28'b0, u_if.rf_waddr}, {28'b0, e.rd});
          chk("rf_wdata", u_if.rf_wdata, e.data);
        end
      end
    end
  end

  initial begin
    u_if.issue_valid = 1'b0; u_if.issue_rd = '0;
    u_if.alu_valid   = 1'b0; u_if.alu_rd   = '0; u_if.alu_data = '0;
    u_if.lsu_valid   = 1'b0; u_if.lsu_rd   = '0; u_if.lsu_data = '0;

    // Reset, then idle
    repeat (2) @(negedge clock);
    chk("rst_busy", {16'b0, u_if.busy}, 32'h0);
    chk("rst_wen", {31'b0, u_if.rf_wen}, 32'h0);
    chk("rst_waddr", {28'b0, u_if.rf_waddr}, 32'h0);
    chk("rst_wdata", u_if.rf_wdata, 32'h0);
    chk("rst_issue_ready", {31'b0, u_if.issue_ready}, 32'h1);
    chk("rst_alu_ready", {31'b0, u_if.alu_ready}, 32'h1);
    step();
    reset = 1'b1;
    step();

    // Issue rd=5, ALU result two cycles later
    u_if.issue_valid = 1'b1; u_if.issue_rd = 4'd5;
    step();
    u_if.issue_valid = 1'b0;
    @(negedge clock);
    chk("busy5_after_issue", {31'b0, u_if.busy[5]}, 32'h1);
    step();
    u_if.alu_valid = 1'b1; u_if.alu_rd = 4'd5; u_if.alu_data = 32'h1234;
    push(4'd5, 32'h1234);
    step();
    u_if.alu_valid = 1'b0;
    @(negedge clock);
    chk("busy5_commit", {31'b0, u_if.busy[5]}, 32'h0);
    chk("wen_commit5", {31'b0, u_if.rf_wen}, 32'h1);
    step();

    // ALU and LSU collide: LSU first
    u_if.issue_valid = 1'b1; u_if.issue_rd = 4'd3;
    step();
    u_if.issue_rd = 4'd4;
    step();
    u_if.issue_valid = 1'b0;
    u_if.alu_valid = 1'b1; u_if.alu_rd = 4'd3; u_if.alu_data = 32'hA;
    u_if.lsu_valid = 1'b1; u_if.lsu_rd = 4'd4; u_if.lsu_data = 32'hB;
    @(negedge clock);
    chk("alu_ready_blocked", {31'b0, u_if.alu_ready}, 32'h0);
    chk("lsu_ready", {31'b0, u_if.lsu_ready}, 32'h1);
    chk("busy_3_4", {16'b0, u_if.busy}, 32'h0018);
    push(4'd4, 32'hB);
    step();
    u_if.lsu_valid = 1'b0;
    @(negedge clock);
    chk("alu_ready_free", {31'b0, u_if.alu_ready}, 32'h1);
    push(4'd3, 32'hA);
    step();
    u_if.alu_valid = 1'b0;
    repeat (2) step();
    chk("busy_after_collide", {16'b0, u_if.busy}, 32'h0);

    // Saturate rd=7
    u_if.issue_valid = 1'b1; u_if.issue_rd = 4'd7;
    repeat (3) step();
    @(negedge clock);
    chk("issue_ready_sat", {31'b0, u_if.issue_ready}, 32'h0);
    step();
    u_if.alu_valid = 1'b1; u_if.alu_rd = 4'd7; u_if.alu_data = 32'h77;
    push(4'd7, 32'h77);
    step();
    u_if.alu_valid = 1'b0;
    @(negedge clock);
    chk("issue_ready_commit7", {31'b0, u_if.issue_ready}, 32'h1);
    chk("busy7_cnt3", {31'b0, u_if.busy[7]}, 32'h1);
    step();
    @(negedge clock);
    chk("issue_ready_still_sat", {31'b0, u_if.issue_ready}, 32'h0);
    u_if.issue_valid = 1'b0;
    u_if.alu_valid = 1'b1; u_if.alu_rd = 4'd7;
    for (int k = 1; k <= 3; k++) begin
      u_if.alu_data = 32'h70 + 32'(k);
      push(4'd7, 32'h70 + 32'(k));
      step();
    end
    u_if.alu_valid = 1'b0;
    @(negedge clock);
    chk("busy7_last_commit", {31'b0, u_if.busy[7]}, 32'h0);
    step();
    chk("busy_drained", {16'b0, u_if.busy}, 32'h0);

    // rd=0 load is dropped
    u_if.lsu_valid = 1'b1; u_if.lsu_rd = 4'd0; u_if.lsu_data = 32'hFFFF_FFFF;
    step();
    u_if.lsu_valid = 1'b0;
    @(negedge clock);
    chk("rd0_wen", {31'b0, u_if.rf_wen}, 32'h0);
    chk("rd0_busy", {16'b0, u_if.busy}, 32'h0);
    step();

    // Reset mid-operation with cnt[2]=2 and a write in flight
    u_if.issue_valid = 1'b1; u_if.issue_rd = 4'd2;
    repeat (2) step();
    u_if.issue_valid = 1'b0;
    u_if.alu_valid = 1'b1; u_if.alu_rd = 4'd2; u_if.alu_data = 32'h22;
    push(4'd2, 32'h22);
    step();
    u_if.alu_valid = 1'b0;
    @(negedge clock);
    chk("busy2_pre_reset", {31'b0, u_if.busy[2]}, 32'h1);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_wen", {31'b0, u_if.rf_wen}, 32'h0);
    chk("mid_rst_waddr", {28'b0, u_if.rf_waddr}, 32'h0);
    chk("mid_rst_wdata", u_if.rf_wdata, 32'h0);
    chk("mid_rst_busy", {16'b0, u_if.busy}, 32'h0);
    step();
    reset = 1'b1;
    step();
    @(negedge clock);
    chk("post_rst_busy2", {31'b0, u_if.busy[2]}, 32'h0);
    u_if.issue_rd = 4'd2;
    #1;
    chk("post_rst_issue_ready", {31'b0, u_if.issue_ready}, 32'h1);
    chk("post_rst_wen", {31'b0, u_if.rf_wen}, 32'h0);

    repeat (3) step();
    chk("pending_writes", exp_q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
